r_pipeline_core: RTL

R_PIPELINE_CORE -- requirements
Module: r_pipeline_core

---
 rtl/r_pipeline_core.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/r_pipeline_core.sv
// rtl/r_pipeline_core.sv - five-stage R-type integer pipeline with EX forwarding and WB-to-ID bypass
// IF/ID, ID/EX, EX/MEM and MEM/WB each carry a valid bit; MEM is a pass-through stage.
module r_pipeline_core #(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       pc_o,
  input  logic [31:0]       instr_i,
  input  logic              stall_i,
  output logic              wb_en_o,
  output logic [4:0]        wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [31:0]       retired_o,
  input  logic [4:0]        dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam logic [5:0]  FN_ADD   = 6'h20;
  localparam logic [5:0]  FN_SUB   = 6'h22;
  localparam logic [5:0]  FN_AND   = 6'h24;
  localparam logic [5:0]  FN_OR    = 6'h25;
  localparam logic [5:0]  FN_SLT   = 6'h2A;
  localparam logic [5:0]  FN_SLL   = 6'h00;
  localparam logic [5:0]  FN_SRL   = 6'h02;
  localparam logic [31:0] DATA_W_U = 32'(DATA_W);

  logic [31:0]       pc_q;
  logic [31:0]       retired_q;
  logic [DATA_W-1:0] rf [32];

  logic              ifid_valid;
  logic [31:0]       ifid_instr;

  logic              idex_valid;
  logic              idex_we;
  logic [4:0]        idex_rs;
  logic [4:0]        idex_rt;
  logic [4:0]        idex_rd;
  logic [4:0]        idex_shamt;
  logic [5:0]        idex_funct;
  logic [DATA_W-1:0] idex_a;
  logic [DATA_W-1:0] idex_b;

  logic              exmem_valid;
  logic              exmem_we;
  logic [4:0]        exmem_rd;
  logic [DATA_W-1:0] exmem_res;

  logic              memwb_valid;
  logic              memwb_we;
  logic [4:0]        memwb_rd;
  logic [DATA_W-1:0] memwb_res;

  logic [5:0]        id_opcode;
  logic [5:0]        id_funct;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [4:0]        id_shamt;
  logic              id_known;
  logic              id_we;
  logic [DATA_W-1:0] id_a;
  logic [DATA_W-1:0] id_b;

  logic              memwb_wr;
  logic              exmem_wr;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_res;
  logic              shamt_big;

  assign id_opcode = ifid_instr[31:26];
  assign id_rs     = ifid_instr[25:21];
  assign id_rt     = ifid_instr[20:16];
  assign id_rd     = ifid_instr[15:11];
  assign id_shamt  = ifid_instr[10:6];
  assign id_funct  = ifid_instr[5:0];

  always_comb begin
    id_known = 1'b0;
    if (id_opcode == 6'd0) begin
      case (id_funct)
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: id_known = 1'b1;
        default: id_known = 1'b0;
      endcase
    end
  end

  // Writes to r0 are dropped at decode so neither the file nor wb_en_o ever sees them.
  assign id_we    = ifid_valid && id_known && (id_rd != 5'd0);
  assign memwb_wr = memwb_valid && memwb_we;
  assign exmem_wr = exmem_valid && exmem_we;

  always_comb begin
    id_a = rf[id_rs];
    if (id_rs == 5'd0)
      id_a = '0;
    else if (memwb_wr && (memwb_rd == id_rs))
      id_a = memwb_res;

    id_b = rf[id_rt];
    if (id_rt == 5'd0)
      id_b = '0;
    else if (memwb_wr && (memwb_rd == id_rt))
      id_b = memwb_res;
  end

  // The youngest producer wins: EX/MEM before MEM/WB before the captured operand.
  always_comb begin
    ex_a = idex_a;
    if (exmem_wr && (exmem_rd != 5'd0) && (exmem_rd == idex_rs))
      ex_a = exmem_res;
    else if (memwb_wr && (memwb_rd != 5'd0) && (memwb_rd == idex_rs))
      ex_a = memwb_res;

    ex_b = idex_b;
    if (exmem_wr && (exmem_rd != 5'd0) && (exmem_rd == idex_rt))
      ex_b = exmem_res;
    else if (memwb_wr && (memwb_rd != 5'd0) && (memwb_rd == idex_rt))
      ex_b = memwb_res;
  end

  assign shamt_big = {27'd0, idex_shamt} >= DATA_W_U;

  always_comb begin
    ex_res = '0;
    case (idex_funct)
      FN_ADD:  ex_res = ex_a + ex_b;
      FN_SUB:  ex_res = ex_a - ex_b;
      FN_AND:  ex_res = ex_a & ex_b;
      FN_OR:   ex_res = ex_a | ex_b;
      FN_SLT:  ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
      FN_SLL:  ex_res = shamt_big ? '0 : (ex_b << idex_shamt);
      FN_SRL:  ex_res = shamt_big ? '0 : (ex_b >> idex_shamt);
      default: ex_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      retired_q   <= '0;
      ifid_valid  <= 1'b0;
      ifid_instr  <= '0;
      idex_valid  <= 1'b0;
      idex_we     <= 1'b0;
      idex_rs     <= '0;
      idex_rt     <= '0;
      idex_rd     <= '0;
      idex_shamt  <= '0;
      idex_funct  <= '0;
      idex_a      <= '0;
      idex_b      <= '0;
      exmem_valid <= 1'b0;
      exmem_we    <= 1'b0;
      exmem_rd    <= '0;
      exmem_res   <= '0;
      memwb_valid <= 1'b0;
      memwb_we    <= 1'b0;
      memwb_rd    <= '0;
      memwb_res   <= '0;
    end else if (!stall_i) begin
      pc_q        <= pc_q + PC_STEP;
      ifid_valid  <= 1'b1;
      ifid_instr  <= instr_i;
      idex_valid  <= ifid_valid;
      idex_we     <= id_we;
      idex_rs     <= id_rs;
      idex_rt     <= id_rt;
      idex_rd     <= id_rd;
      idex_shamt  <= id_shamt;
      idex_funct  <= id_funct;
      idex_a      <= id_a;
      idex_b      <= id_b;
      exmem_valid <= idex_valid;
      exmem_we    <= idex_valid && idex_we;
      exmem_rd    <= idex_rd;
      exmem_res   <= ex_res;
      memwb_valid <= exmem_valid;
      memwb_we    <= exmem_wr;
      memwb_rd    <= exmem_rd;
      memwb_res   <= exmem_res;
      if (memwb_valid)
        retired_q <= retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
    end else if (!stall_i && memwb_wr) begin
      rf[memwb_rd] <= memwb_res;
    end
  end

  assign pc_o       = pc_q;
  assign retired_o  = retired_q;
  assign wb_en_o    = memwb_wr && !stall_i && !rst;
  assign wb_addr_o  = memwb_rd;
  assign wb_data_o  = memwb_res;
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : rf[dbg_addr_i];

endmodule
